// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and branch stall/flush control,
// and a multi-cycle divide sequencer that freezes Fetch/Decode/Execute while it runs.
module hazard_unit #(
  parameter int DIV_LAT = 4,
  parameter int RA_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] Rs1D,
  input  logic [RA_W-1:0] Rs2D,
  input  logic [RA_W-1:0] Rs1E,
  input  logic [RA_W-1:0] Rs2E,
  input  logic [RA_W-1:0] RdE,
  input  logic [RA_W-1:0] RdM,
  input  logic [RA_W-1:0] RdW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            ResultSrcE0,
  input  logic            PCSrcE,
  input  logic            DivStartE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushM,
  output logic            DivBusy,
  output logic            DivDoneE
);

  localparam int CNT_W = $clog2(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [RA_W-1:0]  REG_X0   = {RA_W{1'b0}};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             div_stall;
  logic             lw_stall;
  logic             busy_nxt;
  logic             done_nxt;

  // Memory-stage producer wins over Writeback; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic [RA_W-1:0] rd_m,
    input logic            we_m,
    input logic [RA_W-1:0] rd_w,
    input logic            we_w
  );
    logic [1:0] sel;
    if (we_m && (rd_m != REG_X0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != REG_X0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  assign lw_stall = ResultSrcE0 && (RdE != REG_X0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Divide sequencer next state; the start request is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_stall = 1'b0;
    case (state)
      IDLE: begin
        if (DivStartE) begin
          div_stall = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = BUSY;
        end else begin
          cnt_nxt   = CNT_ZERO;
        end
      end
      BUSY: begin
        if (cnt != CNT_ZERO) begin
          div_stall = 1'b1;
          cnt_nxt   = cnt - CNT_ONE;
        end else begin
          cnt_nxt   = CNT_ZERO;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = CNT_ZERO;
        state_nxt = IDLE;
      end
    endcase
  end

  // Status flags are precomputed from the next state so they leave the unit as flops.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == BUSY) begin
      busy_nxt = (cnt_nxt != CNT_ZERO);
      done_nxt = (cnt_nxt == CNT_ZERO);
    end else begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
    end
  end

  // Sequencer state, counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= CNT_ZERO;
      DivBusy  <= 1'b0;
      DivDoneE <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      DivBusy  <= busy_nxt;
      DivDoneE <= done_nxt;
    end
  end

  // While a divide holds Execute, load-use and branch requests are masked.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (div_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = lw_stall || PCSrcE;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_hazard_unit;

  localparam int DIV_LAT = 4;
  localparam int RA_W    = 5;

  logic            clk;
  logic            rst_n;
  logic [RA_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic            RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, DivStartE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallF, StallD, StallE, FlushD, FlushE, FlushM, DivBusy, DivDoneE;

  int checks = 0;
  int errors = 0;

  // Model: whether a divide is in flight and how many cycles it has already spent in Execute.
  bit m_active;
  int m_k;

  hazard_unit #(.DIV_LAT(DIV_LAT), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .DivStartE(DivStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .DivBusy(DivBusy), .DivDoneE(DivDoneE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
    end else if (!m_active) begin
      if (DivStartE) begin
        m_active <= 1'b1;
        m_k      <= 1;
      end
    end else if (m_k == DIV_LAT - 1) begin
      m_active <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [RA_W-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_check();
    bit lw, dstall;
    lw     = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    dstall = (!m_active && DivStartE) || (m_active && m_k < DIV_LAT - 1);
    chk("m_fwdA",  32'(ForwardAE), 32'(m_fwd(Rs1E)));
    chk("m_fwdB",  32'(ForwardBE), 32'(m_fwd(Rs2E)));
    chk("m_stallF", 32'(StallF), 32'(dstall || lw));
    chk("m_stallD", 32'(StallD), 32'(dstall || lw));
    chk("m_stallE", 32'(StallE), 32'(dstall));
    chk("m_flushM", 32'(FlushM), 32'(dstall));
    chk("m_flushD", 32'(FlushD), 32'(!dstall && PCSrcE));
    chk("m_flushE", 32'(FlushE), 32'(!dstall && (lw || PCSrcE)));
    chk("m_busy",   32'(DivBusy), 32'(m_active && m_k >= 1 && m_k <= DIV_LAT - 2));
    chk("m_done",   32'(DivDoneE), 32'(m_active && m_k == DIV_LAT - 1));
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0; DivStartE = 1'b0;
  endtask

  task automatic settle();
    zero_inputs();
    repeat (DIV_LAT + 1) begin
      sample();
      next();
    end
  endtask

  // Full divide with DivStartE held through the done cycle and dropped afterwards.
  task automatic div_seq(input string tag);
    logic [4:0] exp_stall, exp_busy, exp_done;
    exp_stall = 5'b00111;
    exp_busy  = 5'b00110;
    exp_done  = 5'b01000;
    for (int i = 0; i < 5; i++) begin
      DivStartE = (i < 4);
      sample();
      chk({tag, "_stallE"}, 32'(StallE), 32'(exp_stall[i]));
      chk({tag, "_stallF"}, 32'(StallF), 32'(exp_stall[i]));
      chk({tag, "_busy"},   32'(DivBusy), 32'(exp_busy[i]));
      chk({tag, "_done"},   32'(DivDoneE), 32'(exp_done[i]));
      next();
    end
    DivStartE = 1'b0;
  endtask

  initial begin
    zero_inputs();
    rst_n = 1'b0;
    sample();
    chk("rst_busy", 32'(DivBusy), 32'd0);
    chk("rst_done", 32'(DivDoneE), 32'd0);
    chk("rst_stallE", 32'(StallE), 32'd0);
    next();
    rst_n = 1'b1;
    next();

    // Forwarding priority
    RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
    sample(); chk("fwd_mem", 32'(ForwardAE), 32'd2); next();
    RegWriteM = 1'b0;
    sample(); chk("fwd_wb", 32'(ForwardAE), 32'd1); next();
    RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
    sample(); chk("fwd_x0", 32'(ForwardAE), 32'd0); next();
    zero_inputs();

    // Load-use
    ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    sample();
    chk("lu_stallF", 32'(StallF), 32'd1);
    chk("lu_stallD", 32'(StallD), 32'd1);
    chk("lu_flushE", 32'(FlushE), 32'd1);
    chk("lu_stallE", 32'(StallE), 32'd0);
    next();
    ResultSrcE0 = 1'b0;
    sample(); chk("lu_gone", 32'(StallF), 32'd0); next();
    ResultSrcE0 = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
    sample(); chk("lu_x0", 32'(StallF), 32'd0); chk("lu_x0_fe", 32'(FlushE), 32'd0); next();
    zero_inputs();

    // Branch together with load-use
    ResultSrcE0 = 1'b1; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
    sample();
    chk("bl_stallF", 32'(StallF), 32'd1);
    chk("bl_stallD", 32'(StallD), 32'd1);
    chk("bl_flushD", 32'(FlushD), 32'd1);
    chk("bl_flushE", 32'(FlushE), 32'd1);
    next();
    settle();

    div_seq("div");
    settle();

    // Masking during BUSY
    DivStartE = 1'b1;
    sample(); next();
    PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    sample();
    chk("mask_flushD", 32'(FlushD), 32'd0);
    chk("mask_flushE", 32'(FlushE), 32'd0);
    chk("mask_stallE", 32'(StallE), 32'd1);
    chk("mask_flushM", 32'(FlushM), 32'd1);
    chk("mask_busy",   32'(DivBusy), 32'd1);
    next();
    settle();

    // Reset while the counter holds 1
    DivStartE = 1'b1;
    sample(); next();
    sample(); next();
    DivStartE = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(DivBusy), 32'd0);
    chk("arst_stallE", 32'(StallE), 32'd0);
    chk("arst_stallF", 32'(StallF), 32'd0);
    chk("arst_done",   32'(DivDoneE), 32'd0);
    sample(); next();
    sample(); chk("arst_nodone", 32'(DivDoneE), 32'd0); next();
    rst_n = 1'b1;
    div_seq("post_rst");
    settle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      ResultSrcE0 = 1'($urandom_range(0, 1));
      PCSrcE      = ($urandom_range(0, 3) == 0);
      DivStartE   = ($urandom_range(0, 3) == 0);
      sample();
      next();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter DIV_LAT, default 4, SHALL be the total number of cycles a divide occupies Execute; legal range is 2..64.
REQ-002 Parameter RA_W, default 5, SHALL be the register-address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Rs1D, Rs2D  in  RA_W  SHALL be the source registers of the instruction in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  RA_W  SHALL be the source and destination registers of the instruction in Execute.
REQ-007 RdM, RdW  in  RA_W  SHALL be the destination registers in Memory and Writeback.
REQ-008 RegWriteM, RegWriteW  in  1  SHALL be the write enables in Memory and Writeback.
REQ-009 ResultSrcE0  in  1  SHALL be high when Execute holds a load.
REQ-010 PCSrcE  in  1  SHALL be high when Execute resolves a taken branch or jump.
REQ-011 DivStartE  in  1  SHALL be high while Execute holds a divide; the pipeline holds it high for as long as the divide sits in Execute.
REQ-012 ForwardAE, ForwardBE  out  2  SHALL be the operand selects: 00 = register file, 01 = ResultW, 10 = ALUResultM.
REQ-013 StallF, StallD, StallE  out  1  SHALL be the hold enables for the F, D and E pipeline registers.
REQ-014 FlushD, FlushE, FlushM  out  1  SHALL be the bubble-insert controls for the D, E and M pipeline registers.
REQ-015 DivBusy, DivDoneE  out  1  SHALL be the divider status outputs.

Function
REQ-016 ForwardAE SHALL be 10 when RegWriteM=1, RdM!=0 and RdM==Rs1E; otherwise 01 when RegWriteW=1, RdW!=0 and RdW==Rs1E; otherwise 00. The Memory-stage match has priority.
REQ-017 ForwardBE SHALL follow the same rule as REQ-016, using Rs2E in place of Rs1E.
REQ-018 Register x0 SHALL never be forwarded, regardless of any enable.
REQ-019 Load-use (lwStall) SHALL be asserted when ResultSrcE0=1, RdE!=0, and RdE equals Rs1D or Rs2D.
REQ-020 lwStall SHALL assert StallF, StallD and FlushE in the same cycle, with zero latency (combinational).
REQ-021 PCSrcE=1 SHALL assert FlushD and FlushE in the same cycle.
REQ-022 The divide FSM SHALL have two states, IDLE and BUSY, plus a counter of ceil(log2(DIV_LAT)) bits.
REQ-023 In IDLE with DivStartE=1, the unit SHALL assert StallF, StallD, StallE and FlushM, load the counter with DIV_LAT-2, and enter BUSY.
REQ-024 In BUSY with counter!=0, the unit SHALL assert StallF, StallD, StallE, FlushM and DivBusy, and decrement the counter by one.
REQ-025 In BUSY with counter==0, the unit SHALL deassert all divide stalls, assert DivDoneE for exactly one cycle, and return to IDLE.
REQ-026 A divide SHALL occupy Execute for exactly DIV_LAT cycles and produce exactly DIV_LAT-1 stall cycles.
REQ-027 DivStartE while in BUSY, including the DivDoneE cycle, SHALL be ignored and SHALL NOT restart the divider.
REQ-028 While a divide stall is active, lwStall-driven and PCSrcE-driven outputs SHALL be masked, because Execute holds the divide.
REQ-029 The counter SHALL NOT wrap; it is not decremented below 0.
REQ-030 Simultaneous lwStall and PCSrcE SHALL produce StallF=1, StallD=1, FlushD=1 and FlushE=1; the flush discards the stalled Decode instruction.
REQ-031 ForwardAE and ForwardBE SHALL remain valid during divide stalls.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force state to IDLE, the counter to 0, and DivBusy and DivDoneE to 0.
REQ-033 Stall and flush outputs SHALL then depend only on the combinational hazard terms.
REQ-034 Reset asserted during BUSY SHALL abort the divide with no DivDoneE pulse.
REQ-035 After rst_n is released, the first DivStartE SHALL start a fresh divide of the full DIV_LAT cycles.

Verification
REQ-036 Forwarding priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10; then RegWriteM=0 -> ForwardAE=01; then RdM=RdW=0 -> ForwardAE=00.
REQ-037 Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle; with RdE=0 -> no stall.
REQ-038 Divide (DIV_LAT=4): DivStartE held high -> StallE=1 for cycles t..t+2, DivBusy=1 for t+1..t+2, DivDoneE=1 at t+3 only, StallE=0 at t+3, no restart at t+4 when DivStartE=0.
REQ-039 Mask check: PCSrcE=1 and ResultSrcE0=1 with a load-use match during BUSY -> FlushD=0, FlushE=0, stall pattern unchanged.
REQ-040 Reset mid-divide: rst_n=0 at counter=1 -> DivBusy=0 and stalls=0 immediately, no DivDoneE; DivStartE after release -> 4-cycle divide.
REQ-041 Branch plus load-use in the same cycle -> StallF=StallD=FlushD=FlushE=1.
